tff_mod_counter: RTL

Synchronous modulo-N up/down counter built from per-bit T flip-flop cells. It contains the toggle-generation logic that sits directly upstream of the T cells: each cycle it computes which bits must flip to reach the next count and drives those onto the cells' T inputs. It is used as the standard loadable counter and divider primitive next to the existing T flip-flop, and exposes true and complemented state plus a terminal-count strobe for cascading.

---
 rtl/tff_cnt_pkg.sv | 18 +
 rtl/t_cell.sv | 31 +++
 rtl/tff_mod_counter.sv | 82 ++++++++
 3 files changed

// File: rtl/tff_cnt_pkg.sv
// rtl/tff_cnt_pkg.sv - shared constants and reset helpers for the T-cell modulo counter
package tff_cnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Reset images are returned wide and trimmed by the caller to its own width.
    function automatic logic [63:0] q_rst(input int unsigned w);
        q_rst = (w == 0) ? 64'd0 : 64'd0;
    endfunction

    function automatic logic [63:0] qbar_rst(input int unsigned w);
        logic [63:0] ones;
        ones = '1;
        qbar_rst = (w == 0) ? 64'd0 : (ones >> (64 - w));
    endfunction

endpackage

// File: rtl/t_cell.sv
// rtl/t_cell.sv - one T flip-flop bit with registered true and complemented outputs
module t_cell
    import tff_cnt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qbar
);

    localparam logic Q_INIT    = 1'(q_rst(1));
    localparam logic QBAR_INIT = 1'(qbar_rst(1));

    logic q_q;
    logic qbar_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= Q_INIT;
            qbar_q <= QBAR_INIT;
        end else if (t) begin
            q_q    <= ~q_q;
            qbar_q <= ~qbar_q;
        end
    end

    assign q    = q_q;
    assign qbar = qbar_q;

endmodule

// File: rtl/tff_mod_counter.sv
// rtl/tff_mod_counter.sv - modulo-N up/down counter on T cells; TFF_CNT_LOAD_EN enables parallel load
module tff_mod_counter
    import tff_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("tff_mod_counter: MODULUS out of range for WIDTH");
    end

    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qbar_w;
    logic [WIDTH-1:0] next_d;
    logic [WIDTH-1:0] t_d;
    logic             illegal;
    logic             at_end;
    logic             load_blk;

    assign illegal = ({1'b0, q_w} >= MOD_W);

`ifdef TFF_CNT_LOAD_EN
    assign load_blk = load;
`else
    assign load_blk = 1'b0;
    logic unused_load;
    assign unused_load = &{1'b0, load, din};
`endif

    always_comb begin
        next_d = q_w;
`ifdef TFF_CNT_LOAD_EN
        if (load) begin
            next_d = ({1'b0, din} < MOD_W) ? din : MAX_Q;
        end else
`endif
        if (en) begin
            if (illegal) begin
                next_d = '0;
            end else if (up == DIR_UP) begin
                next_d = (q_w == MAX_Q) ? '0 : q_w + WIDTH'(1);
            end else begin
                next_d = (q_w == '0) ? MAX_Q : q_w - WIDTH'(1);
            end
        end
    end

    // Only bits that differ from the target toggle; hold produces an all-zero vector.
    assign t_d = q_w ^ next_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .t    (t_d[i]),
            .q    (q_w[i]),
            .qbar (qbar_w[i])
        );
    end

    assign at_end = (up == DIR_UP) ? (q_w == MAX_Q) : (q_w == '0);
    assign tc     = rst & en & ~load_blk & at_end;

    assign q    = q_w;
    assign qbar = qbar_w;

endmodule
